// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the MEM-stage access block.
// Holds the FSM state enum, memory-op codes and access-width codes.
package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WR   = 2'b10;

    localparam logic WORD = 1'b1;
    localparam logic BYTE = 1'b0;

    // 2'b11 is treated like MEM_NONE: no memory traffic.
    function automatic logic is_mem_op(input logic [1:0] wr_rd);
        return (wr_rd == MEM_RD) || (wr_rd == MEM_WR);
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for data memory: byte enables, store replication,
// and load lane extraction with zero extension.
module mem_byte_lane
    import mem_stage_pkg::*;
(
    input  logic        i_word_byte,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    always_comb begin
        o_be    = 4'hF;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        if (i_word_byte == BYTE) begin
            o_be    = 4'b0001 << i_lane;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {24'h0, i_rdata[{i_lane, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/mem_stage_access.sv
// MEM stage: drives data memory over req/ack, stalls upstream while busy,
// and retires a registered MEM/WB bundle. Optional macro: MEM_ALIGN_CHECK_EN.
//
// state  | meaning
// IDLE   | accepting EX/MEM bundles; non-mem ops retire next cycle
// ACCESS | dmem_req held with stable addr/data until ack or timeout
module mem_stage_access
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  in_mem_wr_rd,
    input  logic        in_word_byte,
    input  logic [31:0] in_alu_out,
    input  logic [31:0] in_write_data,
    input  logic        in_reg_write,
    input  logic [4:0]  in_reg_dest,
    input  logic [1:0]  in_reg_src,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_reg_dest,
    output logic [1:0]  wb_reg_src,
    output logic [31:0] wb_mem_data,
    output logic [31:0] wb_alu_out,
    output logic        err,
    output logic        misalign
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt;
    logic [1:0]  r_wr_rd;
    logic        r_word_byte;
    logic [31:0] r_alu_out;
    logic [31:0] r_write_data;
    logic        r_reg_write;
    logic [4:0]  r_reg_dest;
    logic [1:0]  r_reg_src;

    logic        w_access;
    logic        w_capture;
    logic        w_pass;
    logic        w_done;
    logic        w_abort;
    logic        w_misalign;
    logic [31:0] w_addr;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_pass      = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_misalign  = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem_op(in_mem_wr_rd)) begin
                        w_pass = 1'b1;
                    end
`ifdef MEM_ALIGN_CHECK_EN
                    else if (in_word_byte == WORD && in_alu_out[1:0] != 2'b00) begin
                        w_misalign = 1'b1;
                    end
`endif
                    else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // An ack on the terminal-count cycle still completes normally.
                if (dmem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == TO_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_wr_rd      <= MEM_NONE;
            r_word_byte  <= BYTE;
            r_alu_out    <= '0;
            r_write_data <= '0;
            r_reg_write  <= 1'b0;
            r_reg_dest   <= '0;
            r_reg_src    <= '0;
        end else if (w_capture) begin
            r_cnt        <= '0;
            r_wr_rd      <= in_mem_wr_rd;
            r_word_byte  <= in_word_byte;
            r_alu_out    <= in_alu_out;
            r_write_data <= in_write_data;
            r_reg_write  <= in_reg_write;
            r_reg_dest   <= in_reg_dest;
            r_reg_src    <= in_reg_src;
        end else if (w_access && !dmem_ack && !w_abort) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_reg_dest  <= '0;
            wb_reg_src   <= '0;
            wb_mem_data  <= '0;
            wb_alu_out   <= '0;
            err          <= 1'b0;
        end else begin
            wb_valid <= w_pass | w_done | w_abort | w_misalign;
            if (w_pass || w_misalign) begin
                wb_reg_write <= in_reg_write & ~w_misalign;
                wb_reg_dest  <= in_reg_dest;
                wb_reg_src   <= in_reg_src;
                wb_mem_data  <= '0;
                wb_alu_out   <= in_alu_out;
            end else if (w_done || w_abort) begin
                wb_reg_write <= r_reg_write & ~w_abort;
                wb_reg_dest  <= r_reg_dest;
                wb_reg_src   <= r_reg_src;
                wb_mem_data  <= (w_done && r_wr_rd == MEM_RD) ? w_load : 32'h0;
                wb_alu_out   <= r_alu_out;
            end
            if (w_abort) err <= 1'b1;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (rst) r_misalign <= 1'b0;
        else     r_misalign <= w_misalign;
    end

    assign misalign = r_misalign;
    assign w_addr   = r_alu_out;
`else
    assign misalign = 1'b0;
    assign w_addr   = (r_word_byte == WORD) ? {r_alu_out[31:2], 2'b00} : r_alu_out;
`endif

    mem_byte_lane u_lane (
        .i_word_byte (r_word_byte),
        .i_lane      (r_alu_out[1:0]),
        .i_wdata     (r_write_data),
        .i_rdata     (dmem_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_rdata     (w_load)
    );

    // Memory-side outputs are quiet outside ACCESS so reset leaves them all 0.
    assign w_access   = (r_state == ACCESS);
    assign stall      = w_access;
    assign dmem_req   = w_access;
    assign dmem_we    = w_access && (r_wr_rd == MEM_WR);
    assign dmem_addr  = w_access ? w_addr  : 32'h0;
    assign dmem_wdata = w_access ? w_wdata : 32'h0;
    assign dmem_be    = w_access ? w_be    : 4'h0;

endmodule

// File: tb/tb_mem_stage_access.sv
// Scoreboard bench for mem_stage_access: directed ops push expected MEM/WB
// bundles; a monitor compares each wb_valid pulse against the queue head.
module tb_mem_stage_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_mem_wr_rd;
    logic        in_word_byte;
    logic [31:0] in_alu_out;
    logic [31:0] in_write_data;
    logic        in_reg_write;
    logic [4:0]  in_reg_dest;
    logic [1:0]  in_reg_src;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_reg_dest;
    logic [1:0]  wb_reg_src;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_alu_out;
    logic        err;
    logic        misalign;

    typedef struct packed {
        logic        rw;
        logic [4:0]  dest;
        logic [1:0]  src;
        logic [31:0] mem;
        logic [31:0] alu;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_stage_access #(.TIMEOUT_CYCLES(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_mem_wr_rd  (in_mem_wr_rd),
        .in_word_byte  (in_word_byte),
        .in_alu_out    (in_alu_out),
        .in_write_data (in_write_data),
        .in_reg_write  (in_reg_write),
        .in_reg_dest   (in_reg_dest),
        .in_reg_src    (in_reg_src),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_reg_dest   (wb_reg_dest),
        .wb_reg_src    (wb_reg_src),
        .wb_mem_data   (wb_mem_data),
        .wb_alu_out    (wb_alu_out),
        .err           (err),
        .misalign      (misalign)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every wb_valid pulse must match the oldest expected bundle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", {31'h0, wb_valid}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_reg_write", {31'h0, wb_reg_write}, {31'h0, e.rw});
                    check("wb_reg_dest",  {27'h0, wb_reg_dest},  {27'h0, e.dest});
                    check("wb_reg_src",   {30'h0, wb_reg_src},   {30'h0, e.src});
                    check("wb_mem_data",  wb_mem_data, e.mem);
                    check("wb_alu_out",   wb_alu_out,  e.alu);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [1:0] op, input logic wb, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic rw, input logic [4:0] dest,
                         input logic [1:0] src);
        in_valid      = 1'b1;
        in_mem_wr_rd  = op;
        in_word_byte  = wb;
        in_alu_out    = addr;
        in_write_data = wdata;
        in_reg_write  = rw;
        in_reg_dest   = dest;
        in_reg_src    = src;
    endtask

    // Called at posedge+1; returns at posedge+1 after the retire cycle.
    task automatic do_mem(input string tag, input logic [1:0] op, input logic wb,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic rw,
                          input logic [4:0] dest, input logic [1:0] src, input int waits,
                          input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_mem);
        drive(op, wb, addr, wdata, rw, dest, src);
        exp_q.push_back('{rw: rw, dest: dest, src: src, mem: exp_mem, alu: addr});
        @(negedge clk);
        check({tag, "_stall_idle"}, {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        // in_valid stays high during ACCESS: the held bundle must not be re-captured.
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clk);
            check({tag, "_stall"}, {31'h0, stall},    32'h1);
            check({tag, "_req"},   {31'h0, dmem_req}, 32'h1);
            check({tag, "_be"},    {28'h0, dmem_be},  {28'h0, exp_be});
            check({tag, "_addr"},  dmem_addr, exp_addr);
            check({tag, "_we"},    {31'h0, dmem_we},  {31'h0, (op == 2'b10)});
            if (op == 2'b10) check({tag, "_wdata"}, dmem_wdata, exp_wdata);
            @(posedge clk); #1;
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h5A5A_5A5A;
        in_valid   = 1'b0;
        @(negedge clk);
        check({tag, "_stall_after"}, {31'h0, stall},    32'h0);
        check({tag, "_req_after"},   {31'h0, dmem_req}, 32'h0);
        check({tag, "_wb_latency"},  {31'h0, wb_valid}, 32'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_mem_wr_rd = 2'b00; in_word_byte = 1'b0;
        in_alu_out = '0; in_write_data = '0; in_reg_write = 1'b0; in_reg_dest = '0;
        in_reg_src = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_stall",    {31'h0, stall},    32'h0);
        check("rst_req",      {31'h0, dmem_req}, 32'h0);
        check("rst_be",       {28'h0, dmem_be},  32'h0);
        check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        check("rst_err",      {31'h0, err},      32'h0);
        check("rst_misalign", {31'h0, misalign}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU op: latency 1, never stalls.
        drive(2'b00, 1'b1, 32'h1234, 32'h0, 1'b1, 5'd5, 2'b10);
        exp_q.push_back('{rw: 1'b1, dest: 5'd5, src: 2'b10, mem: 32'h0, alu: 32'h1234});
        @(negedge clk);
        check("alu_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("alu_wb_latency", {31'h0, wb_valid}, 32'h1);
        check("alu_stall2",     {31'h0, stall},    32'h0);
        @(posedge clk); #1;

        // 2'b11 also means no memory op.
        drive(2'b11, 1'b0, 32'h0000_0777, 32'h0, 1'b1, 5'd12, 2'b01);
        exp_q.push_back('{rw: 1'b1, dest: 5'd12, src: 2'b01, mem: 32'h0, alu: 32'h777});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("op11_req", {31'h0, dmem_req}, 32'h0);
        @(posedge clk); #1;

        do_mem("wld",  2'b01, 1'b1, 32'h100, 32'h0, 1'b1, 5'd7, 2'b01, 3,
               32'hDEAD_BEEF, 4'hF, 32'h100, 32'h0, 32'hDEAD_BEEF);
        do_mem("bst",  2'b10, 1'b0, 32'h203, 32'h1234_56AB, 1'b0, 5'd0, 2'b00, 0,
               32'hFFFF_FFFF, 4'b1000, 32'h203, 32'hABAB_ABAB, 32'h0);
        do_mem("bld",  2'b01, 1'b0, 32'h202, 32'h0, 1'b1, 5'd9, 2'b01, 1,
               32'h11C3_2200, 4'b0100, 32'h202, 32'h0, 32'h0000_00C3);
        do_mem("bld0", 2'b01, 1'b0, 32'h204, 32'h0, 1'b1, 5'd10, 2'b01, 0,
               32'h11C3_22F0, 4'b0001, 32'h204, 32'h0, 32'h0000_00F0);
        do_mem("wst",  2'b10, 1'b1, 32'h300, 32'hCAFE_F00D, 1'b0, 5'd0, 2'b00, 2,
               32'h0, 4'hF, 32'h300, 32'hCAFE_F00D, 32'h0);
        // Ack on the terminal-count cycle wins over the timeout.
        do_mem("tc_ack", 2'b01, 1'b1, 32'h340, 32'h0, 1'b1, 5'd11, 2'b01, 14,
               32'h0BAD_F00D, 4'hF, 32'h340, 32'h0, 32'h0BAD_F00D);
        check("tc_ack_err", {31'h0, err}, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
        drive(2'b01, 1'b1, 32'h102, 32'h0, 1'b1, 5'd3, 2'b01);
        exp_q.push_back('{rw: 1'b0, dest: 5'd3, src: 2'b01, mem: 32'h0, alu: 32'h102});
        @(negedge clk);
        check("mis_req0", {31'h0, dmem_req}, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mis_req1",     {31'h0, dmem_req}, 32'h0);
        check("mis_stall",    {31'h0, stall},    32'h0);
        check("mis_pulse",    {31'h0, misalign}, 32'h1);
        check("mis_wb_valid", {31'h0, wb_valid}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("mis_pulse_end", {31'h0, misalign}, 32'h0);
        @(posedge clk); #1;
`else
        do_mem("wmis", 2'b01, 1'b1, 32'h102, 32'h0, 1'b1, 5'd3, 2'b01, 0,
               32'h7654_3210, 4'hF, 32'h100, 32'h0, 32'h7654_3210);
        check("wmis_misalign", {31'h0, misalign}, 32'h0);
`endif

        // Timeout: 15 request cycles, then abort with reg_write cleared.
        drive(2'b01, 1'b1, 32'h400, 32'h0, 1'b1, 5'd4, 2'b01);
        exp_q.push_back('{rw: 1'b0, dest: 5'd4, src: 2'b01, mem: 32'h0, alu: 32'h400});
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dmem_req !== 1'b1) break;
            n++;
        end
        check("to_req_cycles", n, 32'd15);
        check("to_wb_valid",   {31'h0, wb_valid}, 32'h1);
        check("to_err",        {31'h0, err},      32'h1);
        check("to_stall",      {31'h0, stall},    32'h0);
        @(posedge clk); #1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        check("late_ack_req", {31'h0, dmem_req}, 32'h0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_wb",  {31'h0, wb_valid}, 32'h0);
        check("err_sticky",   {31'h0, err},      32'h1);
        @(posedge clk); #1;

        // Reset in ACCESS: request drops, instruction never retires, err clears.
        drive(2'b01, 1'b1, 32'h500, 32'h0, 1'b1, 5'd6, 2'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rstacc_req_before", {31'h0, dmem_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstacc_req_before_edge", {31'h0, dmem_req}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstacc_req", {31'h0, dmem_req}, 32'h0);
        check("rstacc_err", {31'h0, err},      32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rstacc_wb", {31'h0, wb_valid}, 32'h0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
